mdio_arbitro: RTL and testbench
===============================

// Module: mdio_arbitro
// PURPOSE
//   Round-robin arbiter and sequencer for the shared generador_mdio master.
//   Accepts 32-bit MDIO frames from NUM_REQ requesters and issues one at a
//   time: holds the frame on transaccion and pulses start_stb for one cycle.
//   generador_mdio has no done output, so the block times each frame with a
//   fixed cycle budget, reports completion, and inserts an idle gap.
// PARAMETERS
//   NUM_REQ    4    number of requesters, legal range 2..8
//   TXN_CYCLES 136  clk cycles per frame (64 MDC x 2 clk + 8 margin), >= 2
//   GAP_CYCLES 4    idle clk cycles after completion before next grant, >= 0
//   ID_W       2    localparam = $clog2(NUM_REQ)
// PORTS
//   clk         in   1           system clock, same clock as generador_mdio
//   reset       in   1           synchronous, active-high
//   req_valid   in   NUM_REQ     bit i: requester i has a frame pending
//   req_frame   in   32*NUM_REQ  frame of requester i at [32*i+31:32*i]
//   req_ready   out  NUM_REQ     one-cycle pulse: frame i accepted
//   req_done    out  NUM_REQ     one-cycle pulse: frame i budget elapsed
//   start_stb   out  1           to generador_mdio.start_stb
//   transaccion out  32          to generador_mdio.transaccion
//   grant_id    out  ID_W        index of the last granted requester
//   busy        out  1           high whenever state != IDLE
// BEHAVIOUR
//   - All outputs and internal state are registered.
//   - Reset (any cycle, including mid-frame): state=IDLE, ptr=0, cnt=0.
//     All outputs are 0. Any pending req_done is dropped.
//   - States:
//     - IDLE: if req_valid is nonzero, grant g = first set bit searching
//       ptr, ptr+1, ... mod NUM_REQ. On that edge:
//       - transaccion <= frame g, grant_id <= g
//       - req_ready[g] <= 1, start_stb <= 1
//       - ptr <= (g+1) mod NUM_REQ, cnt <= TXN_CYCLES-1, state <= WAIT
//     - WAIT: cnt decrements each cycle. When cnt==0: req_done[grant_id] <= 1,
//       then state <= GAP with cnt = GAP_CYCLES-1, or state <= IDLE if
//       GAP_CYCLES==0.
//     - GAP: cnt decrements each cycle. When cnt==0, state <= IDLE.
//   - Timing:
//     - start_stb and req_ready are high together for exactly one cycle (c0).
//     - req_done is high in cycle c0+TXN_CYCLES.
//     - Back-to-back start_stb spacing is TXN_CYCLES+GAP_CYCLES+1
//       (= TXN_CYCLES+1 when GAP_CYCLES==0).
//   - Requester handshake: keep req_valid and frame stable until req_ready.
//     - After req_ready, the requester may drop valid or present its next
//       frame on the following cycle.
//     - Dropping valid before grant withdraws the request, with no side effect.
//   - transaccion holds its value from the grant until the next grant. Changes
//     on req_frame during WAIT or GAP have no effect.
//   - req_valid is ignored outside IDLE.
//   - At most one bit of req_ready and of req_done is set in any cycle.
//   - busy is high from c0 through the last GAP cycle. It is low in the cycle
//     a grant is decided (IDLE).
// TESTING
//   1. Hold reset 3 cycles with req_valid=4'b1111 -> all outputs 0, no
//      start_stb. After release, the first grant goes to 0 (grant_id=0).
//   2. req_valid=4'b0100, frame2=32'h5BA73549 -> next cycle:
//      req_ready=4'b0100, start_stb=1, transaccion=32'h5BA73549, grant_id=2.
//      req_done[2] is high exactly 136 cycles after start_stb. busy falls
//      4 cycles after req_done.
//   3. All four requesters always valid -> grant order 0,1,2,3,0.
//      start_stb spacing is 141 cycles. transaccion matches each frame.
//   4. Grant req1 with 32'h65557777, then change frame1 at +20 cycles ->
//      transaccion stays 32'h65557777 until the next grant.
//   5. Assert reset 50 cycles after start_stb -> no req_done, outputs 0.
//      After release, with all requesters valid, the next grant goes to 0.
//   6. GAP_CYCLES=0, two requesters always valid -> spacing 137 cycles.
//      req_done is high in the IDLE cycle that decides the next grant.

Source files
------------

// File: rtl/mdio_arbitro.sv
// ============================================================================
// mdio_arbitro : round-robin arbiter/sequencer feeding one generador_mdio
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mdio_arbitro #(
  parameter  int NUM_REQ    = 4,
  parameter  int TXN_CYCLES = 136,
  parameter  int GAP_CYCLES = 4,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [32*NUM_REQ-1:0] req_frame,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   req_done,
  output logic                 start_stb,
  output logic [31:0]          transaccion,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy
);

  localparam int CNT_MAX = (TXN_CYCLES > GAP_CYCLES) ? TXN_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TXN_LOAD = CNT_W'(TXN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         transaccion_q, transaccion_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  req_done_q, req_done_d;
  logic                start_stb_q, start_stb_d;
  logic                busy_q, busy_d;

  logic                found;
  logic [ID_W-1:0]     grant_sel;
  logic [ID_W:0]       probe;

  // First valid requester at or after ptr, wrapping around NUM_REQ.
  always_comb begin
    found     = 1'b0;
    grant_sel = '0;
    probe     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (probe >= (ID_W+1)'(NUM_REQ)) begin
        probe = probe - (ID_W+1)'(NUM_REQ);
      end
      if (!found && req_valid[probe[ID_W-1:0]]) begin
        found     = 1'b1;
        grant_sel = probe[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    transaccion_d = transaccion_q;
    grant_id_d    = grant_id_q;
    req_ready_d   = '0;
    req_done_d    = '0;
    start_stb_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          transaccion_d          = req_frame[32*grant_sel +: 32];
          grant_id_d             = grant_sel;
          req_ready_d[grant_sel] = 1'b1;
          start_stb_d            = 1'b1;
          ptr_d   = (grant_sel == ID_W'(NUM_REQ - 1)) ? '0 : grant_sel + ID_W'(1);
          cnt_d   = TXN_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          req_done_d[grant_id_q] = 1'b1;
          cnt_d   = GAP_LOAD;
          state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered from the next state so busy is already high in the strobe cycle.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      transaccion_q <= '0;
      grant_id_q    <= '0;
      req_ready_q   <= '0;
      req_done_q    <= '0;
      start_stb_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      transaccion_q <= transaccion_d;
      grant_id_q    <= grant_id_d;
      req_ready_q   <= req_ready_d;
      req_done_q    <= req_done_d;
      start_stb_q   <= start_stb_d;
      busy_q        <= busy_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign req_done    = req_done_q;
  assign start_stb   = start_stb_q;
  assign transaccion = transaccion_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mdio_arbitro.sv
// ============================================================================
// tb_mdio_arbitro : bench for mdio_arbitro (GAP=4 and GAP=0 instances)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdio_arbitro;

  localparam int N    = 4;
  localparam int TXN  = 136;
  localparam int GAP0 = 4;
  localparam int GAP1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [N-1:0]     rv  [2];
  logic [32*N-1:0]  rf  [2];
  logic [N-1:0]     rdy [2];
  logic [N-1:0]     dn  [2];
  logic             stb [2];
  logic [31:0]      tr  [2];
  logic [1:0]       gid [2];
  logic             bsy [2];

  mdio_arbitro #(.NUM_REQ(N), .TXN_CYCLES(TXN), .GAP_CYCLES(GAP0)) dut (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_frame(rf[0]),
    .req_ready(rdy[0]), .req_done(dn[0]), .start_stb(stb[0]),
    .transaccion(tr[0]), .grant_id(gid[0]), .busy(bsy[0])
  );

  mdio_arbitro #(.NUM_REQ(N), .TXN_CYCLES(TXN), .GAP_CYCLES(GAP1)) dut_nogap (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_frame(rf[1]),
    .req_ready(rdy[1]), .req_done(dn[1]), .start_stb(stb[1]),
    .transaccion(tr[1]), .grant_id(gid[1]), .busy(bsy[1])
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting for DUT event", name);
  endtask

  function automatic int gap_of(input int i);
    return (i == 0) ? GAP0 : GAP1;
  endfunction

  // Schedule model: a grant fixes its strobe cycle; done, busy window and the
  // next decision point follow from the cycle budgets alone.
  int          cyc = 0;
  int          m_c0   [2];
  int          m_next [2];
  int          m_g    [2];
  int          m_ptr  [2];
  logic [31:0] m_tr   [2];

  always @(posedge clk) begin
    int g;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_c0[i]   <= -1;
        m_g[i]    <= 0;
        m_ptr[i]  <= 0;
        m_tr[i]   <= '0;
        m_next[i] <= cyc + 1;
      end else if (cyc >= m_next[i] && rv[i] != '0) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && rv[i][(m_ptr[i] + k) % N]) g = (m_ptr[i] + k) % N;
        m_g[i]    <= g;
        m_c0[i]   <= cyc + 1;
        m_tr[i]   <= rf[i][32*g +: 32];
        m_ptr[i]  <= (g + 1) % N;
        m_next[i] <= cyc + 1 + TXN + gap_of(i);
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int i = 0; i < 2; i++) begin
        logic        e_stb, e_busy;
        logic [N-1:0] e_rdy, e_dn;
        e_stb  = (m_c0[i] >= 0) && (cyc == m_c0[i]);
        e_rdy  = e_stb ? N'(1 << m_g[i]) : '0;
        e_dn   = (m_c0[i] >= 0 && cyc == m_c0[i] + TXN) ? N'(1 << m_g[i]) : '0;
        e_busy = (m_c0[i] >= 0) && (cyc >= m_c0[i]) && (cyc < m_c0[i] + TXN + gap_of(i));
        check($sformatf("u%0d start_stb @%0d", i, cyc), 32'(stb[i]), 32'(e_stb));
        check($sformatf("u%0d req_ready @%0d", i, cyc), 32'(rdy[i]), 32'(e_rdy));
        check($sformatf("u%0d req_done @%0d", i, cyc), 32'(dn[i]), 32'(e_dn));
        check($sformatf("u%0d busy @%0d", i, cyc), 32'(bsy[i]), 32'(e_busy));
        check($sformatf("u%0d transaccion @%0d", i, cyc), tr[i], m_tr[i]);
        check($sformatf("u%0d grant_id @%0d", i, cyc), 32'(gid[i]), 32'(m_g[i]));
      end
    end
  end

  task automatic wait_stb(input int i, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (stb[i] === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) timeout($sformatf("u%0d start_stb", i));
  endtask

  task automatic wait_idle(input int i, input int budget, output int n);
    bit ok = 1'b0;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (bsy[i] === 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) timeout($sformatf("u%0d busy low", i));
  endtask

  task automatic wait_done(input int i, input int budget, output int n);
    bit ok = 1'b0;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (dn[i] !== '0) begin ok = 1'b1; break; end
    end
    if (!ok) timeout($sformatf("u%0d req_done", i));
  endtask

  initial begin
    bit ok;
    int n, last, done_seen;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    // Reset held 3 cycles with everyone requesting.
    reset = 1'b1;
    rv[0] = 4'b1111;
    rv[1] = 4'b0000;
    rf[0] = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    rf[1] = {32'hD000_0003, 32'hC000_0002, 32'hB000_0001, 32'hA000_0000};
    repeat (3) @(negedge clk);
    check("reset start_stb", 32'(stb[0]), 32'd0);
    check("reset transaccion", tr[0], 32'd0);
    check("reset busy", 32'(bsy[0]), 32'd0);
    reset = 1'b0;
    wait_stb(0, 10, ok);
    check("first grant id", 32'(gid[0]), 32'd0);
    check("first grant frame", tr[0], 32'h1111_0000);
    rv[0] = '0;
    wait_idle(0, 300, n);

    // Single requester 2: strobe, done latency and gap length.
    rv[0] = 4'b0100;
    rf[0][95:64] = 32'h5BA73549;
    wait_stb(0, 5, ok);
    check("t2 req_ready", 32'(rdy[0]), 32'b0100);
    check("t2 transaccion", tr[0], 32'h5BA73549);
    check("t2 grant_id", 32'(gid[0]), 32'd2);
    rv[0] = '0;
    wait_done(0, 200, n);
    check("t2 done latency", n, 32'd136);
    check("t2 done vector", 32'(dn[0]), 32'b0100);
    wait_idle(0, 20, n);
    check("t2 busy fall after done", n, 32'd4);

    // All valid from a fresh pointer: rotation and spacing.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rv[0] = 4'b1111;
    last = 0;
    for (int j = 0; j < 5; j++) begin
      wait_stb(0, 200, ok);
      check($sformatf("t3 grant %0d id", j), 32'(gid[0]), 32'(exp_order[j]));
      check($sformatf("t3 grant %0d frame", j), tr[0], rf[0][32*exp_order[j] +: 32]);
      if (j > 0) check($sformatf("t3 spacing %0d", j), cyc - last, 32'd141);
      last = cyc;
    end
    rv[0] = '0;
    wait_idle(0, 300, n);

    // Frame latched at grant; later edits only land at the next grant.
    rv[0] = 4'b0010;
    rf[0][63:32] = 32'h65557777;
    wait_stb(0, 10, ok);
    check("t4 grant id", 32'(gid[0]), 32'd1);
    check("t4 frame", tr[0], 32'h65557777);
    rv[0] = '0;
    repeat (20) @(negedge clk);
    rf[0][63:32] = 32'hDEADBEEF;
    rv[0] = 4'b0010;
    wait_idle(0, 300, n);
    check("t4 frame held to idle", tr[0], 32'h65557777);
    wait_stb(0, 5, ok);
    check("t4 new frame", tr[0], 32'hDEADBEEF);
    rv[0] = '0;
    wait_idle(0, 300, n);

    // Reset mid-frame drops the pending done and rewinds the pointer.
    rv[0] = 4'b1111;
    wait_stb(0, 10, ok);
    check("t5 grant id before reset", 32'(gid[0]), 32'd2);
    repeat (50) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("t5 busy in reset", 32'(bsy[0]), 32'd0);
    check("t5 transaccion in reset", tr[0], 32'd0);
    check("t5 grant_id in reset", 32'(gid[0]), 32'd0);
    reset = 1'b0;
    wait_stb(0, 5, ok);
    check("t5 grant id after reset", 32'(gid[0]), 32'd0);
    rv[0] = '0;
    done_seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (dn[0] !== '0) done_seen++;
    end
    check("t5 no stale done", done_seen, 32'd0);
    wait_idle(0, 300, n);

    // Zero-gap instance: done coincides with the next decision.
    rv[1] = 4'b0011;
    wait_stb(1, 5, ok);
    check("t6 first id", 32'(gid[1]), 32'd0);
    last = cyc;
    wait_done(1, 200, n);
    check("t6 done latency", n, 32'd136);
    check("t6 done vector", 32'(dn[1]), 32'b0001);
    check("t6 idle at done", 32'(bsy[1]), 32'd0);
    wait_stb(1, 5, ok);
    check("t6 spacing", cyc - last, 32'd137);
    check("t6 second id", 32'(gid[1]), 32'd1);
    rv[1] = '0;
    wait_idle(1, 300, n);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
